// File: rtl/spwm_pkg.sv
// spwm_pkg: shared types and constants for the sinusoidal-PWM stage
package spwm_pkg;

   typedef enum logic [1:0] {LO, HI, DEAD} dead_state_t;

   localparam int DEF_DATA_W      = 8;
   localparam int DEF_DEAD_CYCLES = 8;
   localparam int CARRIER_MAX     = 2**DEF_DATA_W - 1;
   localparam int CARRIER_PERIOD  = 2 * CARRIER_MAX;

endpackage

// File: rtl/dead_time_gen.sv
// dead_time_gen: complementary gate drive with dead-time from a PWM reference
module dead_time_gen
   import spwm_pkg::*;
#(
   parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic pwm_ref,
   output logic pwm_hi,
   output logic pwm_lo
);

   localparam int CW = $clog2(DEAD_CYCLES + 2);
   localparam logic [CW-1:0] DC = CW'(DEAD_CYCLES);

   dead_state_t state, state_n;
   logic tgt, tgt_n;
   logic [CW-1:0] dcnt, dcnt_n;

   // next state: leave an on-state through DEAD, retarget on any reference change while dead
   always_comb begin
      state_n = state;
      tgt_n   = tgt;
      dcnt_n  = (dcnt < DC) ? dcnt + 1'b1 : dcnt;
      if (!enable) begin
         state_n = DEAD;
         tgt_n   = 1'b0;
         dcnt_n  = '0;
      end else if (state == HI && !pwm_ref) begin
         state_n = (DEAD_CYCLES == 0) ? LO : DEAD;
         tgt_n   = 1'b0;
         dcnt_n  = CW'(1);
      end else if (state == LO && pwm_ref) begin
         state_n = (DEAD_CYCLES == 0) ? HI : DEAD;
         tgt_n   = 1'b1;
         dcnt_n  = CW'(1);
      end else if (state == DEAD && pwm_ref != tgt) begin
         tgt_n   = pwm_ref;
         dcnt_n  = CW'(1);
      end else if (state == DEAD && dcnt >= DC) begin
         state_n = tgt ? HI : LO;
      end
   end

   // state register; gates are decoded from the next state so they leave flops directly
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state  <= DEAD;
         tgt    <= 1'b0;
         dcnt   <= '0;
         pwm_hi <= 1'b0;
         pwm_lo <= 1'b0;
      end else begin
         state  <= state_n;
         tgt    <= tgt_n;
         dcnt   <= dcnt_n;
         pwm_hi <= state_n == HI;
         pwm_lo <= state_n == LO;
      end

endmodule

// File: rtl/spwm_gen.sv
// spwm_gen: DDS-addressed sine sample compared against a triangle carrier to drive one inverter leg
module spwm_gen
   import spwm_pkg::*;
#(
   parameter int PHASE_W     = 32,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [PHASE_W-1:0] tuning_word,
   input  logic               tw_load,
   output logic [ADDR_W-1:0]  sample_addr,
   input  logic [DATA_W-1:0]  sample_data,
   output logic               pwm_hi,
   output logic               pwm_lo,
   output logic               carrier_sync,
   output logic [DATA_W-1:0]  duty_q
);

   localparam logic [DATA_W-1:0] CMAX = '1;

   logic [DATA_W-1:0]  cnt, shadow;
   logic               dir_down, valley, ref_on;
   logic [PHASE_W-1:0] phase, phase_n, tw_pending, tw_active;

   assign valley  = enable && cnt == '0;
   assign phase_n = phase + tw_active;
   assign ref_on  = enable && (cnt < duty_q);

   // symmetric triangle carrier 0..MAX..1, parked at the valley while disabled
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt      <= '0;
         dir_down <= 1'b0;
      end else if (!enable) begin
         cnt      <= '0;
         dir_down <= 1'b0;
      end else if (!dir_down) begin
         cnt      <= (cnt == CMAX) ? CMAX - 1'b1 : cnt + 1'b1;
         dir_down <= cnt == CMAX;
      end else begin
         cnt      <= cnt - 1'b1;
         dir_down <= cnt != DATA_W'(1);
      end

   // tuning word double-buffer and phase step once per carrier period at the valley
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         tw_pending  <= '0;
         tw_active   <= '0;
         phase       <= '0;
         sample_addr <= '0;
      end else begin
         if (tw_load)
            tw_pending <= tuning_word;
         if (valley) begin
            tw_active   <= tw_pending;
            phase       <= phase_n;
            sample_addr <= phase_n[PHASE_W-1 -: ADDR_W];
         end
      end

   // sample taken early on the up-ramp, promoted to the compare value only at the peak
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         shadow       <= '0;
         duty_q       <= '0;
         carrier_sync <= 1'b0;
      end else begin
         if (enable && !dir_down && cnt == DATA_W'(1))
            shadow <= sample_data;
         if (enable && cnt == CMAX)
            duty_q <= shadow;
         carrier_sync <= valley;
      end

   dead_time_gen #(.DEAD_CYCLES(DEAD_CYCLES)) u_dead (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .pwm_ref (ref_on),
      .pwm_hi  (pwm_hi),
      .pwm_lo  (pwm_lo)
   );

endmodule

// File: tb/tb_spwm_gen.sv
// tb_spwm_gen: directed self-checking bench for spwm_gen
module tb_spwm_gen;
   import spwm_pkg::*;

   logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, tw_load = 1'b0;
   logic [31:0] tuning_word = '0;
   logic [15:0] sample_addr;
   logic [7:0]  sample_data = '0, duty_q;
   logic        pwm_hi, pwm_lo, carrier_sync;
   int          checks = 0, errors = 0;

   spwm_gen dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .tuning_word  (tuning_word),
      .tw_load      (tw_load),
      .sample_addr  (sample_addr),
      .sample_data  (sample_data),
      .pwm_hi       (pwm_hi),
      .pwm_lo       (pwm_lo),
      .carrier_sync (carrier_sync),
      .duty_q       (duty_q)
   );

   always #5 clk = ~clk;

   // gates must never overlap
   always @(negedge clk)
      assert (!(pwm_hi && pwm_lo)) else begin
         errors++;
         $display("FAIL overlap: pwm_hi=%0b pwm_lo=%0b at %0t", pwm_hi, pwm_lo, $time);
      end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_sync();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!carrier_sync && k < 600);
      checks++;
      if (carrier_sync !== 1'b1) begin
         errors++;
         $display("FAIL wait_sync: carrier_sync=%0b after %0d cycles, need 1", carrier_sync, k);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      checks += 5;
      if (sample_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h need 0000", sample_addr); end
      if (duty_q !== 8'h0)       begin errors++; $display("FAIL reset_duty: got %h need 00", duty_q); end
      if (pwm_hi !== 1'b0)       begin errors++; $display("FAIL reset_hi: got %b need 0", pwm_hi); end
      if (pwm_lo !== 1'b0)       begin errors++; $display("FAIL reset_lo: got %b need 0", pwm_lo); end
      if (carrier_sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b need 0", carrier_sync); end
      reset = 1'b0;
      tick(3);
   endtask

   task automatic test_startup();
      int first_lo = 0, s1 = 0, s2 = 0;
      bit hi_seen = 0, addr_nz = 0;
      sample_data = 8'd0;
      enable = 1'b1;
      for (int k = 1; k <= 520; k++) begin
         @(negedge clk);
         if (pwm_lo && first_lo == 0) first_lo = k;
         if (pwm_hi) hi_seen = 1;
         if (sample_addr !== 16'h0) addr_nz = 1;
         if (carrier_sync) begin
            if (s1 == 0) s1 = k;
            else if (s2 == 0) s2 = k;
         end
      end
      checks += 5;
      if (first_lo != 9) begin errors++; $display("FAIL startup_lo_rise: got cycle %0d need 9", first_lo); end
      if (hi_seen)       begin errors++; $display("FAIL startup_hi: got high need never"); end
      if (addr_nz)       begin errors++; $display("FAIL startup_addr: got nonzero need 0000"); end
      if (s1 != 1)       begin errors++; $display("FAIL startup_sync1: got cycle %0d need 1", s1); end
      if (s2 != 1 + CARRIER_PERIOD) begin errors++; $display("FAIL startup_sync2: got cycle %0d need %0d", s2, 1 + CARRIER_PERIOD); end
   endtask

   task automatic test_phase();
      logic [15:0] exp [5];
      exp = '{16'h0000, 16'hC000, 16'h8000, 16'h4000, 16'h0000};
      tuning_word = 32'hC000_0000;
      tw_load = 1'b1;
      tick(1);
      tw_load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_sync();
         checks++;
         if (sample_addr !== exp[i]) begin errors++; $display("FAIL phase_addr%0d: got %h need %h", i, sample_addr, exp[i]); end
      end
   endtask

   task automatic test_coincident();
      wait_sync();
      checks++;
      if (sample_addr !== 16'hC000) begin errors++; $display("FAIL coin_pre: got %h need C000", sample_addr); end
      tick(509);
      tuning_word = 32'h4000_0000;
      tw_load = 1'b1;
      tick(1);
      tw_load = 1'b0;
      checks += 2;
      if (carrier_sync !== 1'b1)    begin errors++; $display("FAIL coin_sync: got %b need 1", carrier_sync); end
      if (sample_addr !== 16'h8000) begin errors++; $display("FAIL coin_v0: got %h need 8000", sample_addr); end
      wait_sync();
      checks++;
      if (sample_addr !== 16'h4000) begin errors++; $display("FAIL coin_v1: got %h need 4000", sample_addr); end
      wait_sync();
      checks++;
      if (sample_addr !== 16'h8000) begin errors++; $display("FAIL coin_v2: got %h need 8000", sample_addr); end
   endtask

   task automatic test_duty_half();
      int hi = 0, lo = 0, off = 0;
      sample_data = 8'd128;
      tick(1100);
      for (int k = 0; k < CARRIER_PERIOD; k++) begin
         @(negedge clk);
         if (pwm_hi) hi++;
         if (pwm_lo) lo++;
         if (!pwm_hi && !pwm_lo) off++;
      end
      checks += 4;
      if (duty_q !== 8'd128) begin errors++; $display("FAIL half_duty: got %0d need 128", duty_q); end
      if (hi != 247)         begin errors++; $display("FAIL half_hi: got %0d need 247", hi); end
      if (lo != 247)         begin errors++; $display("FAIL half_lo: got %0d need 247", lo); end
      if (off != 16)         begin errors++; $display("FAIL half_off: got %0d need 16", off); end
   endtask

   task automatic test_duty_full();
      int hi = 0, lo = 0, run = 0, max_run = 0;
      sample_data = 8'd255;
      tick(1100);
      for (int k = 0; k < 2 * CARRIER_PERIOD; k++) begin
         @(negedge clk);
         if (pwm_hi) hi++;
         if (pwm_lo) lo++;
         run = pwm_hi ? 0 : run + 1;
         if (run > max_run) max_run = run;
      end
      checks += 4;
      if (duty_q !== 8'd255) begin errors++; $display("FAIL full_duty: got %0d need 255", duty_q); end
      if (lo != 0)           begin errors++; $display("FAIL full_lo: got %0d need 0", lo); end
      if (hi != 1002)        begin errors++; $display("FAIL full_hi: got %0d need 1002", hi); end
      if (max_run != 9)      begin errors++; $display("FAIL full_gap: got %0d need 9", max_run); end
   endtask

   task automatic test_disable();
      enable = 1'b0;
      tick(1);
      checks += 2;
      if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin errors++; $display("FAIL dis_gates: got hi=%b lo=%b need 0 0", pwm_hi, pwm_lo); end
      tick(20);
      if (duty_q !== 8'd255) begin errors++; $display("FAIL dis_duty: got %0d need 255", duty_q); end
      enable = 1'b1;
      tick(1);
      checks++;
      if (carrier_sync !== 1'b1) begin errors++; $display("FAIL reen_sync: got %b need 1", carrier_sync); end
   endtask

   task automatic test_reset_async();
      int k = 0;
      while (!pwm_hi && k < 600) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (pwm_hi !== 1'b1) begin errors++; $display("FAIL rst_pre_hi: got %b need 1", pwm_hi); end
      #2 reset = 1'b1;
      #1;
      checks += 4;
      if (pwm_hi !== 1'b0)       begin errors++; $display("FAIL rst_hi: got %b need 0", pwm_hi); end
      if (pwm_lo !== 1'b0)       begin errors++; $display("FAIL rst_lo: got %b need 0", pwm_lo); end
      if (sample_addr !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h need 0000", sample_addr); end
      if (duty_q !== 8'h0)       begin errors++; $display("FAIL rst_duty: got %h need 00", duty_q); end
      @(negedge clk);
      reset = 1'b0;
      tick(1);
      checks += 2;
      if (carrier_sync !== 1'b1) begin errors++; $display("FAIL post_rst_sync: got %b need 1", carrier_sync); end
      if (sample_addr !== 16'h0) begin errors++; $display("FAIL post_rst_addr: got %h need 0000", sample_addr); end
      wait_sync();
      checks++;
      if (sample_addr !== 16'h0) begin errors++; $display("FAIL post_rst_addr2: got %h need 0000", sample_addr); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_phase();
      test_coincident();
      test_duty_half();
      test_duty_full();
      test_disable();
      test_reset_async();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
